// File: rtl/ffd_pkg.sv
// ---------------------------------------------------------------------------
// ffd_pkg
// Shared definitions for the ffd_pipeline register pipeline: default
// geometry and the helper that sizes the occupancy counter.
// ---------------------------------------------------------------------------
package ffd_pkg;

    localparam int FFD_DEFAULT_WIDTH = 8;
    localparam int FFD_DEFAULT_DEPTH = 4;

    // Bits needed to hold any occupancy value 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ffd_pipeline_if.sv
// ---------------------------------------------------------------------------
// ffd_pipeline_if
// Streaming bundle around ffd_pipeline: upstream valid/ready/data,
// downstream valid/ready/data, the flush request and the occupancy count.
//   master : the environment (drives in_*, out_ready, flush)
//   slave  : the pipeline    (drives in_ready, out_valid, out_data, count)
// ---------------------------------------------------------------------------
interface ffd_pipeline_if #(
    parameter int WIDTH = ffd_pkg::FFD_DEFAULT_WIDTH,
    parameter int DEPTH = ffd_pkg::FFD_DEFAULT_DEPTH
);

    logic                                   in_valid;
    logic                                   in_ready;
    logic [WIDTH-1:0]                       in_data;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [WIDTH-1:0]                       out_data;
    logic                                   flush;
    logic [ffd_pkg::cnt_width(DEPTH)-1:0]   count;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/ffd_stage.sv
// ---------------------------------------------------------------------------
// ffd_stage
// One valid+data register pair of the pipeline.
//   aclk, srst  : clock, synchronous active-high reset
//   flush       : clear valid, hold data
//   adv         : this stage may take the upstream word this edge
//   prev_valid  : upstream valid (input transfer flag for stage 0)
//   prev_data   : upstream payload
//   valid, data : registered stage contents
// ---------------------------------------------------------------------------
module ffd_stage
    import ffd_pkg::*;
#(
    parameter int               WIDTH       = FFD_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             aclk,
    input  logic             srst,
    input  logic             flush,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state: data only loads with a real word, so bubbles never toggle it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (adv) begin
            valid_d = prev_valid;
            if (prev_valid) begin
                data_d = prev_data;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/ffd_pipeline.sv
// ---------------------------------------------------------------------------
// ffd_pipeline
// DEPTH-stage valid/ready register pipeline with bubble collapsing,
// synchronous flush and an occupancy counter.
//   aclk : clock (rising edge)
//   srst : synchronous active-high reset, highest priority
//   bus  : ffd_pipeline_if slave port (in_*, out_*, flush, count)
// out_valid/out_data come straight from the last stage registers.
// ---------------------------------------------------------------------------
module ffd_pipeline
    import ffd_pkg::*;
#(
    parameter int               WIDTH       = FFD_DEFAULT_WIDTH,
    parameter int               DEPTH       = FFD_DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic          aclk,
    input  logic          srst,
    ffd_pipeline_if.slave bus
);

    localparam int CW = cnt_width(DEPTH);

    if (DEPTH < 1) begin : g_depth_check
        $error("ffd_pipeline: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] valid_s;
    logic [WIDTH-1:0] data_s [DEPTH];
    logic [DEPTH-1:0] adv_s;
    logic             in_ready_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    count_q;

    // Ready chain, walked from the output side: a stage advances when it
    // is empty or everything downstream of it advances.
    always_comb begin : p_ready_chain
        logic open_s;
        adv_s  = {DEPTH{1'b0}};
        open_s = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            open_s   = open_s | ~valid_s[i];
            adv_s[i] = open_s;
        end
    end

    assign in_ready_s = adv_s[0] & ~bus.flush;
    assign in_xfer_s  = bus.in_valid & in_ready_s;
    assign out_xfer_s = valid_s[DEPTH-1] & bus.out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             prev_valid_s;
        logic [WIDTH-1:0] prev_data_s;

        if (i == 0) begin : g_head
            assign prev_valid_s = in_xfer_s;
            assign prev_data_s  = bus.in_data;
        end else begin : g_body
            assign prev_valid_s = valid_s[i-1];
            assign prev_data_s  = data_s[i-1];
        end

        ffd_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .aclk       (aclk),
            .srst       (srst),
            .flush      (bus.flush),
            .adv        (adv_s[i]),
            .prev_valid (prev_valid_s),
            .prev_data  (prev_data_s),
            .valid      (valid_s[i]),
            .data       (data_s[i])
        );
    end

    // Occupancy next value; a flush empties the pipe even if a word leaves.
    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = {CW{1'b0}};
        end else begin
            count_d = count_q + CW'(in_xfer_s) - CW'(out_xfer_s);
        end
    end

    // Occupancy register.
    always_ff @(posedge aclk) begin
        if (srst) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = valid_s[DEPTH-1];
    assign bus.out_data  = data_s[DEPTH-1];
    assign bus.count     = count_q;

endmodule

// File: tb/tb_ffd_pipeline.sv
// ---------------------------------------------------------------------------
// tb_ffd_pipeline
// Self-checking bench for ffd_pipeline (WIDTH=8, DEPTH=4, RESET_VALUE=A5).
// The reference model keeps the words in flight as a queue of
// {data, position}; words slide toward the output unless the word ahead
// blocks them, and the head leaves when out_ready is high.
// ---------------------------------------------------------------------------
module tb_ffd_pipeline;
    import ffd_pkg::*;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RV    = 8'hA5;

    typedef struct {
        logic [7:0] data;
        int         pos;
    } item_t;

    logic aclk = 1'b0;
    logic srst;

    ffd_pipeline_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ffd_pipeline #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RV)
    ) dut (
        .aclk (aclk),
        .srst (srst),
        .bus  (bus)
    );

    always #5 aclk = ~aclk;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         chk_en   = 1'b0;
    int         cyc      = 0;
    bit         last_ov;
    bit         last_ir;
    item_t      mq[$];
    logic [7:0] m_last = RV;
    logic [7:0] outs[$];
    int         ocyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: advance the in-flight words by one clock edge.
    task automatic m_step(input bit iv, input logic [7:0] id, input bit ordy,
                          input bit fl, input bit rst, input bit exp_ir, input bit exp_ov);
        item_t t;
        int    bound;
        int    np;
        if (rst) begin
            mq.delete();
            m_last = RV;
            return;
        end
        if (fl) begin
            mq.delete();
            return;
        end
        if (exp_ov && ordy) void'(mq.pop_front());
        for (int k = 0; k < mq.size(); k++) begin
            t     = mq[k];
            bound = (k == 0) ? DEPTH - 1 : mq[k-1].pos - 1;
            np    = (t.pos + 1 < bound) ? t.pos + 1 : bound;
            if (np == DEPTH - 1 && t.pos != DEPTH - 1) m_last = t.data;
            t.pos = np;
            mq[k] = t;
        end
        if (iv && exp_ir) begin
            t.data = id;
            t.pos  = 0;
            mq.push_back(t);
            if (DEPTH == 1) m_last = id;
        end
    endtask

    // One clock cycle: drive, check against the model, step the model.
    task automatic cycle(input bit iv, input logic [7:0] id, input bit ordy,
                         input bit fl, input bit rst, output bit acc);
        bit exp_ir;
        bit exp_ov;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.flush     = fl;
        srst          = rst;
        #2;
        exp_ir = ((mq.size() < DEPTH) || ordy) && !fl;
        exp_ov = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
        if (chk_en) begin
            chk("in_ready",  32'(bus.in_ready),  32'(exp_ir));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            chk("out_data",  32'(bus.out_data),  32'(m_last));
            chk("count",     32'(bus.count),     32'(mq.size()));
        end
        last_ov = (bus.out_valid === 1'b1);
        last_ir = (bus.in_ready === 1'b1);
        if (last_ov && ordy) begin
            outs.push_back(bus.out_data);
            ocyc.push_back(cyc);
        end
        acc = iv && exp_ir;
        m_step(iv, id, ordy, fl, rst, exp_ir, exp_ov);
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    initial begin
        bit         acc;
        int         c;
        int         hs;
        int         fo;
        int         lo;
        int         nov;
        int         w;
        int         nacc;
        logic [7:0] rd;

        // Reset: 3 cycles of srst; the first one runs from unknown state.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        chk_en = 1'b1;
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'h0000_00A5);
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Latency / throughput: 0x01..0x10 back to back, out_ready high.
        hs = -1; fo = -1; lo = -1; nov = 0;
        for (int i = 1; i <= 16 + 8; i++) begin
            c = cyc;
            if (i <= 16) cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, acc);
            else         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
            if (acc && hs < 0) hs = c;
            if (last_ov) begin
                nov++;
                if (fo < 0) fo = c;
                lo = c;
            end
        end
        chk("latency",    32'(fo - hs),     32'(DEPTH));
        chk("stream_cnt", 32'(nov),         32'd16);
        chk("stream_gap", 32'(lo - fo + 1), 32'd16);
        for (int i = 0; i < 16; i++) chk("stream_order", 32'(outs[i]), 32'(i + 1));

        // Backpressure fill: only four of 0x11..0x16 fit.
        outs.delete(); ocyc.delete();
        w = 0; nacc = 0;
        repeat (6) begin
            cycle(1'b1, 8'h11 + 8'(w), 1'b0, 1'b0, 1'b0, acc);
            if (last_ir) nacc++;
            if (acc) w++;
        end
        chk("fill_accepted", 32'(nacc),         32'd4);
        chk("fill_count",    32'(bus.count),    32'd4);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 12; i++) begin
            cycle(w < 6, 8'h11 + 8'(w), 1'b1, 1'b0, 1'b0, acc);
            if (i == 0) chk("drain_in_ready", 32'(last_ir), 32'd1);
            if (acc) w++;
        end
        chk("drain_cnt", 32'(outs.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("drain_order", 32'(outs[i]), 32'h11 + 32'(i));

        // Bubble collapse.
        outs.delete(); ocyc.delete();
        cycle(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, acc);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, acc);
        chk("bubble_count", 32'(bus.count), 32'd2);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
        chk("bubble_cnt", 32'(outs.size()), 32'd2);
        if (outs.size() == 2) begin
            chk("bubble_first",  32'(outs[0]), 32'h21);
            chk("bubble_second", 32'(outs[1]), 32'h22);
            chk("bubble_b2b",    32'(ocyc[1] - ocyc[0]), 32'd1);
        end

        // Flush with the head word at the output and out_ready high.
        cycle(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        outs.delete(); ocyc.delete();
        cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, acc);
        chk("flush_in_ready", 32'(last_ir),       32'd0);
        chk("flush_count",    32'(bus.count),     32'd0);
        chk("flush_out_valid",32'(bus.out_valid), 32'd0);
        repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
        chk("flush_outs", 32'(outs.size()), 32'd1);
        if (outs.size() == 1) chk("flush_head", 32'(outs[0]), 32'h31);

        // Reset mid-operation on a full pipe, together with flush and in_valid.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 1'b0, acc);
        chk("full_count", 32'(bus.count), 32'd4);
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, acc);
        bus.in_valid = 1'b0; bus.flush = 1'b0; srst = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_out_data",  32'(bus.out_data),  32'h0000_00A5);
        chk("mrst_count",     32'(bus.count),     32'd0);
        chk("mrst_in_ready",  32'(bus.in_ready),  32'd1);
        outs.delete(); ocyc.delete();
        repeat (6) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
        chk("mrst_no_output", 32'(outs.size()), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rd = 8'($urandom);
            cycle($urandom_range(0, 1) == 1, rd,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 99) == 0, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
